reg_file_32x32: RTL



---
 rtl/reg_file_32x32_pkg.sv | 12 +
 rtl/reg_file_32x32_onehot_chk.sv | 21 ++
 rtl/reg_file_32x32.sv | 72 +++++++
 3 files changed

// File: rtl/reg_file_32x32_pkg.sv
// Register-file constants shared by the write-address decoder, this storage
// stage and the datapath.
package reg_file_32x32_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

  // Register 0 reads as zero unless an instance explicitly turns this off.
  localparam bit RF_ZERO_REG = 1'b1;

endpackage

// File: rtl/reg_file_32x32_onehot_chk.sv
// Classifies a select vector as one-hot or multi-hot without a popcount.
// Clearing the lowest set bit (x & (x-1)) leaves something only when 2+ bits were set.
module onehot_chk #(
  parameter int DEPTH = 32
) (
  input  logic [DEPTH-1:0] X,
  output logic             IsOneHot,
  output logic             IsMulti
);

  logic [DEPTH-1:0] lowCleared;
  logic             anySet;

  always_comb begin
    lowCleared = X & (X - {{(DEPTH-1){1'b0}}, 1'b1});
    anySet     = |X;
    IsMulti    = |lowCleared;
    IsOneHot   = anySet & ~IsMulti;
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 32x32 register file fed by the registered one-hot write decoder: write data
// is delayed one edge to line up with Sel, reads are asynchronous with write-first bypass.
module reg_file_32x32
  import reg_file_32x32_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter bit ZERO_REG = RF_ZERO_REG
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DEPTH-1:0]     Sel,
  input  logic [WIDTH-1:0]     WData,
  input  logic [RF_ADDR_W-1:0] RAddA,
  input  logic [RF_ADDR_W-1:0] RAddB,
  output logic [WIDTH-1:0]     RDataA,
  output logic [WIDTH-1:0]     RDataB,
  output logic                 SelErr
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] wDataQ;
  logic             isOneHot;
  logic             isMulti;
  logic             bypassA;
  logic             bypassB;

  onehot_chk #(.DEPTH(DEPTH)) u_onehot_chk (
    .X        (Sel),
    .IsOneHot (isOneHot),
    .IsMulti  (isMulti)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wDataQ <= '0;
    end else begin
      wDataQ <= WData;
    end
  end

  // Register 0 is never written when hardwired, so its reset value is permanent.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (isOneHot) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (Sel[i] && !(ZERO_REG && i == 0)) begin
          regs[i] <= wDataQ;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      SelErr <= 1'b0;
    end else if (isMulti) begin
      SelErr <= 1'b1;
    end
  end

  always_comb begin
    bypassA = isOneHot && Sel[RAddA] && !(ZERO_REG && RAddA == '0);
    bypassB = isOneHot && Sel[RAddB] && !(ZERO_REG && RAddB == '0);
    RDataA  = bypassA ? wDataQ : regs[RAddA];
    RDataB  = bypassB ? wDataQ : regs[RAddB];
  end

endmodule
